// File: rtl/id_pkg.sv
// ----------------------------------------------------------------------------
// id_pkg
//   Shared definitions for the multi-stream identifier recognizer:
//   - per-stream context state encoding (IDLE / ALPHA / NUM)
//   - character-class bounds for letters and digits
//   - is_letter / is_digit classification helpers
//   No ports; imported by id_step and id_ctx_scheduler.
// ----------------------------------------------------------------------------
package id_pkg;

   // Saved recognizer state per stream. Encoding 3 is never written by the
   // design; the step function treats it as IDLE should it ever appear.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALPHA = 2'd1,
      ST_NUM   = 2'd2
   } ctx_state_e;

   // Character-class bounds (ASCII)
   localparam logic [7:0] CH_UA = 8'h41;
   localparam logic [7:0] CH_UZ = 8'h5A;
   localparam logic [7:0] CH_LA = 8'h61;
   localparam logic [7:0] CH_LZ = 8'h7A;
   localparam logic [7:0] CH_D0 = 8'h30;
   localparam logic [7:0] CH_D9 = 8'h39;

   function automatic logic is_letter(input logic [7:0] c);
      return ((c >= CH_UA) && (c <= CH_UZ)) || ((c >= CH_LA) && (c <= CH_LZ));
   endfunction

   function automatic logic is_digit(input logic [7:0] c);
      return (c >= CH_D0) && (c <= CH_D9);
   endfunction

endpackage

// File: rtl/id_step.sv
// ----------------------------------------------------------------------------
// id_step
//   Purely combinational identifier-recognition step: letters then digits.
//   Ports:
//     state      in  ctx_state_e  saved state of the stream being served
//     ch         in  8            character being consumed
//     next_state out ctx_state_e  state to write back for that stream
//     out        out 1            high while a digit extends a letter-led token
// ----------------------------------------------------------------------------
module id_step
   import id_pkg::*;
(
   input  ctx_state_e  state,
   input  logic [7:0]  ch,
   output ctx_state_e  next_state,
   output logic        out
);

   // One step of the recognizer. Anything that does not extend the current
   // token drops back to IDLE; a letter after digits ends the token rather
   // than starting a new one. The default arm also absorbs the unused
   // encoding so a corrupted context recovers as IDLE.
   always_comb begin
      next_state = ST_IDLE;
      out        = 1'b0;
      case (state)
         ST_ALPHA: begin
            if (is_letter(ch)) begin
               next_state = ST_ALPHA;
            end else if (is_digit(ch)) begin
               next_state = ST_NUM;
               out        = 1'b1;
            end
         end
         ST_NUM: begin
            if (is_digit(ch)) begin
               next_state = ST_NUM;
               out        = 1'b1;
            end
         end
         default: begin
            if (is_letter(ch)) begin
               next_state = ST_ALPHA;
            end
         end
      endcase
   end

endmodule

// File: rtl/id_ctx_scheduler.sv
// ----------------------------------------------------------------------------
// id_ctx_scheduler
//   Time-shares one id_step among NREQ character streams. A round-robin
//   arbiter accepts at most one character per cycle, steps that stream's
//   saved context and returns a tagged match result one cycle later.
//   Ports:
//     clk        in  1        rising-edge clock
//     reset_n    in  1        asynchronous active-low reset
//     req_valid  in  NREQ     stream i has a character this cycle
//     req_char   in  8*NREQ   character of stream i at [8i+7:8i]
//     req_ready  out NREQ     one-hot grant (combinational)
//     ctx_clear  in  NREQ     force stream i's context to IDLE at next edge
//     res_valid  out 1        a character was consumed last cycle
//     res_id     out IDW      stream index of that character
//     res_match  out 1        recognizer output for that character
// ----------------------------------------------------------------------------
module id_ctx_scheduler
   import id_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
)(
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [8*NREQ-1:0]   req_char,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ-1:0]     ctx_clear,
   output logic                res_valid,
   output logic [IDW-1:0]      res_id,
   output logic                res_match
);

   logic [IDW-1:0] rr_ptr;
   logic [IDW:0]   scan_sum;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_any;
   ctx_state_e     ctx [NREQ];
   logic [7:0]     char_lane [NREQ];
   ctx_state_e     step_next;
   logic           step_out;

   // Split the flat character bus into one lane per stream so the grant
   // mux below can index it directly.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         char_lane[i] = req_char[8*i +: 8];
      end
   end

   // Round-robin search starting at rr_ptr and wrapping. The sum is one bit
   // wider than the index so the wrap can be done by a single subtract,
   // which keeps the search correct for non-power-of-two NREQ.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_sum = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
         if (scan_sum >= (IDW+1)'(NREQ)) begin
            scan_sum = scan_sum - (IDW+1)'(NREQ);
         end
         if (!gnt_any && req_valid[scan_sum[IDW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_sum[IDW-1:0];
         end
      end
   end

   // One-hot grant; all-zero when nobody is asking.
   always_comb begin
      req_ready = '0;
      if (gnt_any) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // The single shared recognizer, fed with the granted stream's saved
   // context and character.
   id_step u_step (
      .state      (ctx[gnt_idx]),
      .ch         (char_lane[gnt_idx]),
      .next_state (step_next),
      .out        (step_out)
   );

   // Context write-back, pointer advance and result registers. A clear on a
   // stream wins over the step write-back and suppresses the match for a
   // character consumed in the same cycle, but the character still counts
   // as consumed. Without a grant the result tag and match hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREQ; i++) begin
            ctx[i] <= ST_IDLE;
         end
         rr_ptr    <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_match <= 1'b0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (ctx_clear[i]) begin
               ctx[i] <= ST_IDLE;
            end else if (gnt_any && (gnt_idx == IDW'(i))) begin
               ctx[i] <= step_next;
            end
         end
         res_valid <= gnt_any;
         if (gnt_any) begin
            rr_ptr    <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
            res_id    <= gnt_idx;
            res_match <= step_out & ~ctx_clear[gnt_idx];
         end
      end
   end

endmodule
